fifo_flags: RTL and testbench

// - Synchronous FIFO with 12-bit words and occupancy flags. It sits on both sides of the 4-way arbiter.
// - Upstream instances hold ingress traffic. Each one drives empty[i] and receives pop[i] and data_out.
// - Downstream instances take push[i] and data from the arbiter, and report almost_full[i] back to it.
// - Word format: [11:10] class, [9:8] dest, [7:0] payload. The FIFO does not interpret the word.

---
 rtl/fifo_flags.sv | 64 ++++++
 tb/tb_fifo_flags.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with registered read data and flags decoded from the registered count.
// Optional FIFO_ERROR_STICKY_EN: error latches until reset instead of pulsing for one cycle.
module fifo_flags #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AF_TH = 6,
  parameter int AE_TH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok, err_ev;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_TH));
  assign almost_empty = (count <= CW'(AE_TH));

  // A push into a full FIFO is only legal when a pop frees a slot on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign err_ev  = (push & ~push_ok) | (pop & ~pop_ok);

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      error    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (push_ok & ~pop_ok)      count <= count + CW'(1);
      else if (pop_ok & ~push_ok) count <= count - CW'(1);
`ifdef FIFO_ERROR_STICKY_EN
      error <= error | err_ev;
`else
      error <= err_ev;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed and randomized checks of fifo_flags against a queue-based model.
module tb_fifo_flags;
  localparam int WIDTH = 12, DEPTH = 8, AF_TH = 6, AE_TH = 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0, pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty, error;
  logic [CW-1:0]    count;

  int total = 0, bad = 0;

  // reference model: ordered queue of stored words plus expected registered outputs
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_err  = 1'b0;

`ifdef FIFO_ERROR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, and return 1ns after the edge.
  task automatic do_cycle(input logic p, input logic pp, input logic [WIDTH-1:0] d);
    bit was_full, was_empty, pop_ok, push_ok, ev;
    push = p; pop = pp; data_in = d;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    pop_ok  = pp && !was_empty;
    push_ok = p && (!was_full || pop_ok);
    ev      = (p && !push_ok) || (pp && !pop_ok);
    if (pop_ok)  m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    m_err = STICKY ? (m_err | ev) : ev;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic model_reset();
    q.delete(); m_dout = '0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12 reset = 1'b1;
    @(posedge clk); #1;
    total += 7;
    if (empty !== 1'b1)        begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    if (full !== 1'b0)         begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    if (almost_full !== 1'b0)  begin bad++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    if (count !== '0)          begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (data_out !== 12'h000)  begin bad++; $display("FAIL reset_dout got=%h exp=000", data_out); end
    if (error !== 1'b0)        begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] w;
    for (int i = 1; i <= 8; i++) begin
      w = WIDTH'(12'h101 * i);
      do_cycle(1'b1, 1'b0, w);
      total += 3;
      if (count !== CW'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      if (almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, i >= 6); end
      if (full !== (i == 8)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 8); end
    end
    for (int i = 1; i <= 8; i++) begin
      do_cycle(1'b0, 1'b1, '0);
      w = WIDTH'(12'h101 * i);
      total++;
      if (data_out !== w) begin bad++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, data_out, w); end
    end
    total += 2;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
    if (error !== 1'b0) begin bad++; $display("FAIL drain_error got=%b exp=0", error); end
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH-1:0] exp_seq[$];
    logic [WIDTH-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = WIDTH'($urandom);
      exp_seq.push_back(w);
      do_cycle(1'b1, 1'b0, w);
    end
    for (int i = 0; i < 4; i++) exp_seq.push_back(12'hABC);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b1, 12'hABC);
      w = exp_seq.pop_front();
      total += 3;
      if (count !== CW'(DEPTH)) begin bad++; $display("FAIL fpp_count[%0d] got=%0d exp=%0d", i, count, DEPTH); end
      if (error !== 1'b0) begin bad++; $display("FAIL fpp_error[%0d] got=%b exp=0", i, error); end
      if (data_out !== w) begin bad++; $display("FAIL fpp_dout[%0d] got=%h exp=%h", i, data_out, w); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 1'b1, '0);
      w = exp_seq.pop_front();
      total++;
      if (data_out !== w) begin bad++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, data_out, w); end
    end
  endtask

  task automatic test_errors();
    logic [WIDTH-1:0] held;
    held = data_out;
    do_cycle(1'b0, 1'b1, '0);   // underflow
    total += 3;
    if (error !== 1'b1) begin bad++; $display("FAIL uf_error got=%b exp=1", error); end
    if (count !== '0) begin bad++; $display("FAIL uf_count got=%0d exp=0", count); end
    if (data_out !== held) begin bad++; $display("FAIL uf_dout got=%h exp=%h", data_out, held); end
    do_cycle(1'b0, 1'b0, '0);
    total++;
    if (error !== STICKY) begin bad++; $display("FAIL uf_after got=%b exp=%b", error, STICKY); end
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, WIDTH'(12'h010 + i));
    do_cycle(1'b1, 1'b0, 12'hEEE);   // overflow, word must be dropped
    total += 3;
    if (error !== 1'b1) begin bad++; $display("FAIL of_error got=%b exp=1", error); end
    if (count !== CW'(DEPTH)) begin bad++; $display("FAIL of_count got=%0d exp=%0d", count, DEPTH); end
    if (data_out !== held) begin bad++; $display("FAIL of_dout got=%h exp=%h", data_out, held); end
    do_cycle(1'b0, 1'b0, '0);
    total++;
    if (error !== STICKY) begin bad++; $display("FAIL of_after got=%b exp=%b", error, STICKY); end
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 1'b1, '0);
      total++;
      if (data_out !== WIDTH'(12'h010 + i)) begin
        bad++; $display("FAIL of_drain[%0d] got=%h exp=%h", i, data_out, 12'h010 + i);
      end
    end
  endtask

  task automatic test_empty_push_pop();
    logic [WIDTH-1:0] held;
    held = data_out;
    do_cycle(1'b1, 1'b1, 12'h3C5);
    total += 3;
    if (count !== CW'(1)) begin bad++; $display("FAIL epp_count got=%0d exp=1", count); end
    if (data_out !== held) begin bad++; $display("FAIL epp_dout got=%h exp=%h", data_out, held); end
    if (error !== 1'b1) begin bad++; $display("FAIL epp_error got=%b exp=1", error); end
    do_cycle(1'b0, 1'b1, '0);
    total += 2;
    if (data_out !== 12'h3C5) begin bad++; $display("FAIL epp_read got=%h exp=3c5", data_out); end
    if (empty !== 1'b1) begin bad++; $display("FAIL epp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_random(input int n);
    bit p, pp;
    int sz;
    for (int i = 0; i < n; i++) begin
      // bias toward filling or draining in phases so both ends get exercised
      p  = ($urandom_range(0, 99) < ((i / 40) % 2 ? 30 : 75));
      pp = ($urandom_range(0, 99) < ((i / 40) % 2 ? 75 : 30));
      do_cycle(p, pp, WIDTH'($urandom));
      sz = q.size();
      total++;
      if (count !== CW'(sz) || empty !== (sz == 0) || full !== (sz == DEPTH) ||
          almost_full !== (sz >= AF_TH) || almost_empty !== (sz <= AE_TH) ||
          data_out !== m_dout || error !== m_err) begin
        bad++;
        $display("FAIL rand[%0d] got cnt=%0d e=%b f=%b af=%b ae=%b d=%h err=%b exp cnt=%0d d=%h err=%b",
                 i, count, empty, full, almost_full, almost_empty, data_out, error, sz, m_dout, m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, WIDTH'($urandom));
    do_cycle(1'b0, 1'b1, '0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    total += 7;
    if (count !== '0)          begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
    if (empty !== 1'b1)        begin bad++; $display("FAIL ar_empty got=%b exp=1", empty); end
    if (almost_empty !== 1'b1) begin bad++; $display("FAIL ar_ae got=%b exp=1", almost_empty); end
    if (full !== 1'b0)         begin bad++; $display("FAIL ar_full got=%b exp=0", full); end
    if (almost_full !== 1'b0)  begin bad++; $display("FAIL ar_af got=%b exp=0", almost_full); end
    if (data_out !== 12'h000)  begin bad++; $display("FAIL ar_dout got=%h exp=000", data_out); end
    if (error !== 1'b0)        begin bad++; $display("FAIL ar_error got=%b exp=0", error); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    // traffic after reset must start from a clean FIFO
    do_cycle(1'b1, 1'b0, 12'h5A5);
    do_cycle(1'b0, 1'b1, '0);
    total += 2;
    if (data_out !== 12'h5A5) begin bad++; $display("FAIL ar_post_dout got=%h exp=5a5", data_out); end
    if (count !== '0) begin bad++; $display("FAIL ar_post_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_errors();
    test_empty_push_pop();
    test_random(400);
    test_async_reset();
    test_random(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
